// File: rtl/rom_bus_ctl.sv
// rom_bus_ctl
// Read controller between the 68000 bus and three banks of 8K x 16 program ROM.
// Each bank is a hi/lo pair of 8K x 8 synchronous ROMs with one-cycle
// registered read latency. The block decodes the ROM window, drives the
// shared ROM address and one-hot bank enable, captures the returned word,
// and generates DTACK.
//
// Window: byte addresses 0x000000-0x00BFFF, three 16 KB banks.
//   bank  = A[15:14] (cpu_a_i[14:13])
//   rom_a = A[13:1]  (cpu_a_i[12:0])
//
// Optional feature: define ROM_LASTWORD_CACHE_EN to add a one-entry cache of
// the last captured word. A read that hits it is acknowledged one edge after
// AS is sampled low, without enabling any ROM.
//
// Ports
//   clk_i          system clock, shared with the ROMs
//   reset_i        synchronous active-high reset
//   cpu_a_i        68000 word address A[23:1] (bit k carries A[k+1])
//   cpu_as_n_i     address strobe, active low, synchronous to clk_i
//   cpu_rw_i       1 = read, 0 = write
//   cpu_d_o        read data; holds its last value between cycles
//   cpu_d_oe_o     high while this block owns the data bus
//   cpu_dtack_n_o  data acknowledge, active low
//   rom_a_o        shared ROM word address
//   rom_ce_o       one-hot bank clock enable
//   rom_oe_o       output enable to all ROMs
//   rom_dhi_i      bank0..2 high bytes, bank n at [8n+7:8n]
//   rom_dlo_i      bank0..2 low bytes, same packing
//
// state     | meaning
// S_IDLE    | waiting for a strobed cycle in the window
// S_FETCH   | bank enabled, ROM registering the word
// S_CAPTURE | ROM word on its outputs, capture and acknowledge
// S_HOLD    | acknowledge held until AS is sampled high

module rom_bus_ctl (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [22:0] cpu_a_i,
  input  logic        cpu_as_n_i,
  input  logic        cpu_rw_i,
  output logic [15:0] cpu_d_o,
  output logic        cpu_d_oe_o,
  output logic        cpu_dtack_n_o,
  output logic [12:0] rom_a_o,
  output logic [2:0]  rom_ce_o,
  output logic        rom_oe_o,
  input  logic [23:0] rom_dhi_i,
  input  logic [23:0] rom_dlo_i
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPTURE, S_HOLD} state_t;

  state_t      state_q;
  logic [1:0]  bank_q;
  logic [15:0] cpu_d_q;
  logic        cpu_d_oe_q;
  logic        cpu_dtack_n_q;
  logic [12:0] rom_a_q;
  logic [2:0]  rom_ce_q;
  logic        rom_oe_q;

  logic [1:0]  req_bank;
  logic [12:0] req_addr;
  logic        in_window;
  logic        as_req;
  logic [2:0]  req_ce;
  logic [15:0] rom_word;
  logic        cache_hit;

  assign req_bank  = cpu_a_i[14:13];
  assign req_addr  = cpu_a_i[12:0];
  // bank 3 (0x00C000-0x00FFFF) is not populated
  assign in_window = (cpu_a_i[22:15] == 8'd0) && (req_bank != 2'b11);
  assign as_req    = !cpu_as_n_i && in_window;
  assign req_ce    = 3'b001 << req_bank;

  always_comb begin
    rom_word = {rom_dhi_i[7:0], rom_dlo_i[7:0]};
    case (bank_q)
      2'd1:    rom_word = {rom_dhi_i[15:8],  rom_dlo_i[15:8]};
      2'd2:    rom_word = {rom_dhi_i[23:16], rom_dlo_i[23:16]};
      default: rom_word = {rom_dhi_i[7:0],   rom_dlo_i[7:0]};
    endcase
  end

`ifdef ROM_LASTWORD_CACHE_EN
  logic        cache_valid_q;
  logic [1:0]  cache_bank_q;
  logic [12:0] cache_addr_q;
  logic [15:0] cache_word_q;

  assign cache_hit = cache_valid_q && (cache_bank_q == req_bank) &&
                     (cache_addr_q == req_addr);
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      bank_q        <= 2'd0;
      cpu_d_q       <= 16'h0000;
      cpu_d_oe_q    <= 1'b0;
      cpu_dtack_n_q <= 1'b1;
      rom_a_q       <= 13'd0;
      rom_ce_q      <= 3'b000;
      rom_oe_q      <= 1'b0;
`ifdef ROM_LASTWORD_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_bank_q  <= 2'd0;
      cache_addr_q  <= 13'd0;
      cache_word_q  <= 16'h0000;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (as_req) begin
            if (!cpu_rw_i) begin
              // writes to ROM are acknowledged but never drive the bus
              cpu_dtack_n_q <= 1'b0;
              state_q       <= S_HOLD;
            end else if (cache_hit) begin
`ifdef ROM_LASTWORD_CACHE_EN
              cpu_d_q       <= cache_word_q;
`endif
              cpu_dtack_n_q <= 1'b0;
              cpu_d_oe_q    <= 1'b1;
              state_q       <= S_HOLD;
            end else begin
              rom_a_q  <= req_addr;
              bank_q   <= req_bank;
              rom_ce_q <= req_ce;
              rom_oe_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          rom_ce_q <= 3'b000;
          state_q  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // an aborted cycle still completes; HOLD releases it next edge
          cpu_d_q       <= rom_word;
          cpu_dtack_n_q <= 1'b0;
          cpu_d_oe_q    <= 1'b1;
          rom_oe_q      <= 1'b0;
          state_q       <= S_HOLD;
`ifdef ROM_LASTWORD_CACHE_EN
          cache_valid_q <= 1'b1;
          cache_bank_q  <= bank_q;
          cache_addr_q  <= rom_a_q;
          cache_word_q  <= rom_word;
`endif
        end
        S_HOLD: begin
          if (cpu_as_n_i) begin
            cpu_dtack_n_q <= 1'b1;
            cpu_d_oe_q    <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_d_o       = cpu_d_q;
  assign cpu_d_oe_o    = cpu_d_oe_q;
  assign cpu_dtack_n_o = cpu_dtack_n_q;
  assign rom_a_o       = rom_a_q;
  assign rom_ce_o      = rom_ce_q;
  assign rom_oe_o      = rom_oe_q;

endmodule
